// File: rtl/sm_imem_arbiter.sv
`timescale 1ns/1ps
// sm_imem_arbiter
// Shares one combinational instruction-ROM read port between NCORES cores.
// One fetch is granted per cycle, round-robin. The ROM word is returned one
// cycle later on a broadcast data bus, with a per-core valid strobe.
// core_en masks a core's requests so that core can be halted or stepped.
//
// Ports
//   clk       system clock, all state updates on posedge
//   rst       synchronous reset, active-high
//   core_en   per-core run enable (0 masks that core's requests)
//   req       per-core fetch request
//   addr      packed fetch addresses, core i at [i*AW +: AW]
//   gnt       one-hot grant, combinational, same cycle as req
//   rvalid    one-hot registered strobe for the core granted last cycle
//   rdata     registered fetch data, broadcast to all cores
//   rom_addr  address to the shared ROM (0 when nothing is granted)
//   rom_data  ROM read data, combinational from rom_addr
//   busy_cnt  saturating count of cycles with an enabled request left waiting
module sm_imem_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    core_en,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES*AW-1:0] addr,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data,
  output logic [7:0]           busy_cnt
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0] ereq_s;
  logic [NCORES-1:0] gnt_s;
  logic [PW-1:0]     winner_s;
  logic              found_s;
  logic [AW-1:0]     rom_addr_s;

  logic [PW-1:0]     rr_ptr_q,   rr_ptr_d;
  logic [NCORES-1:0] rvalid_q,   rvalid_d;
  logic [DW-1:0]     rdata_q,    rdata_d;
  logic [7:0]        busy_cnt_q, busy_cnt_d;

  assign ereq_s = req & core_en;

  // Round-robin pick: first enabled request at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found_s  = 1'b0;
    winner_s = '0;
    idx      = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NCORES) begin
        idx = idx - NCORES;
      end else begin
        idx = idx;
      end
      if (!found_s && ereq_s[idx]) begin
        found_s  = 1'b1;
        winner_s = PW'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant vector and ROM address from the winner; both idle at zero.
  always_comb begin
    gnt_s      = '0;
    rom_addr_s = '0;
    if (found_s) begin
      gnt_s      = {{(NCORES-1){1'b0}}, 1'b1} << winner_s;
      rom_addr_s = addr[int'(winner_s)*AW +: AW];
    end else begin
      gnt_s      = '0;
      rom_addr_s = '0;
    end
  end

  // Next-state: capture data on a grant, advance the pointer past the winner.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rvalid_d   = gnt_s;
    rdata_d    = rdata_q;
    busy_cnt_d = busy_cnt_q;
    if (found_s) begin
      rdata_d = rom_data;
      if (winner_s == PW'(NCORES-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner_s + PW'(1);
      end
    end else begin
      rdata_d  = rdata_q;
      rr_ptr_d = rr_ptr_q;
    end
    // Someone enabled is still waiting this cycle; stick at 255.
    if (((ereq_s & ~gnt_s) != '0) && (busy_cnt_q != 8'd255)) begin
      busy_cnt_d = busy_cnt_q + 8'd1;
    end else begin
      busy_cnt_d = busy_cnt_q;
    end
  end

  // State registers; reset discards any pending rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      busy_cnt_q <= 8'd0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign gnt      = gnt_s;
  assign rom_addr = rom_addr_s;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_sm_imem_arbiter.sv
`timescale 1ns/1ps
module tb_sm_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  core_en = 4'b1111;
  logic [3:0]  req = 4'b0000;
  logic [127:0] addr;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [31:0] rdata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  busy_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] addr_tbl [4];

  always #5 clk = ~clk;

  // Bench ROM contents: 0x10 holds 0xA, everything else a simple formula.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hA;
    return a * 32'd3 + 32'h100;
  endfunction

  assign addr_tbl[0] = 32'h10;
  assign addr_tbl[1] = 32'h20;
  assign addr_tbl[2] = 32'h30;
  assign addr_tbl[3] = 32'h40;
  assign addr = {addr_tbl[3], addr_tbl[2], addr_tbl[1], addr_tbl[0]};
  assign rom_data = rom_fn(rom_addr);

  sm_imem_arbiter #(.NCORES(4), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .core_en  (core_en),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy_cnt (busy_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check combinational outputs at posedge+3.
  task automatic step(input logic rs, input logic [3:0] en, input logic [3:0] rq,
                      input logic [3:0] eg, input int eb);
    logic [31:0] ea;
    rst = rs;
    core_en = en;
    req = rq;
    #2;
    ea = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) ea = addr_tbl[i];
    end
    check("gnt", {28'd0, gnt}, {28'd0, eg});
    check("rom_addr", rom_addr, ea);
    if (eb >= 0) check("busy_cnt", {24'd0, busy_cnt}, eb);
    if (eg != 4'd0 && !rs) exp_q.push_back({eg, rom_fn(ea)});
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_rvalid", {28'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", {24'd0, busy_cnt}, 32'd0);
  endtask

  // Monitor: every strobe must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!$isunknown(rvalid) && rvalid != 4'd0) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", {28'd0, rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid", {28'd0, rvalid}, {28'd0, e.v});
          check("rdata", rdata, e.d);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    @(posedge clk);
    #1;
    // Reset
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, -1);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 0);
    check_reset_state();

    // Single fetch: grant now, data next cycle
    step(1'b0, 4'b1111, 4'b0001, 4'b0001, 0);
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 0);

    // All four requesting for 8 cycles from reset
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 8; k++) begin
      g = 4'b0001 << (k % 4);
      step(1'b0, 4'b1111, 4'b1111, g, k);
    end
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 8);

    // Cores 1 and 3 only
    step(1'b0, 4'b1111, 4'b1010, 4'b0010, 8);
    step(1'b0, 4'b1111, 4'b1010, 4'b1000, 9);
    step(1'b0, 4'b1111, 4'b1010, 4'b0010, 10);

    // Masked request is never granted and does not count as waiting
    step(1'b0, 4'b1011, 4'b0100, 4'b0000, 11);
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 11);

    // Mask drops right after a grant: data still delivered
    step(1'b0, 4'b1111, 4'b0100, 4'b0100, 11);
    step(1'b0, 4'b1011, 4'b0100, 4'b0000, 11);
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 11);

    // Reset in the cycle after a grant
    step(1'b0, 4'b1111, 4'b0001, 4'b0001, 11);
    step(1'b1, 4'b1111, 4'b0000, 4'b0000, 11);
    check_reset_state();
    step(1'b0, 4'b1111, 4'b1111, 4'b0001, 0);
    // Reset in the same cycle as a grant: pending data discarded
    step(1'b1, 4'b1111, 4'b1111, 4'b0010, 1);
    check_reset_state();
    step(1'b0, 4'b1111, 4'b0000, 4'b0000, 0);
    step(1'b0, 4'b1111, 4'b1111, 4'b0001, 0);

    // Long contention saturates busy_cnt
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 1);
    for (int k = 0; k < 300; k++) begin
      g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      step(1'b0, 4'b0011, 4'b0011, g, (k < 255) ? k : 255);
    end
    step(1'b0, 4'b0011, 4'b0000, 4'b0000, 255);
    step(1'b0, 4'b0011, 4'b0000, 4'b0000, 255);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
